// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the PC, issues one fetch at a time over a
// valid/ready memory port and presents the fetched word to the decoder.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam logic [1:0] ST_REQ  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        kill_q, kill_d;
  logic        req_fire_s;
  logic        out_fire_s;
  logic [31:0] redir_tgt_s;

  assign imem_req_valid = (state_q == ST_REQ) & ~rst;
  assign out_valid      = (state_q == ST_HOLD) & ~redirect_valid & ~rst;
  assign imem_req_addr  = pc_q;
  assign out_pc         = pc_q;
  assign out_inst       = inst_q;

  assign req_fire_s  = imem_req_valid & imem_req_ready;
  assign out_fire_s  = out_valid & out_ready;
  assign redir_tgt_s = {redirect_pc[31:2], 2'b00};

  // Next-state logic; kill marks an in-flight fetch whose response must be dropped
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    kill_d  = kill_q;
    case (state_q)
      ST_REQ: begin
        if (req_fire_s) begin
          state_d = ST_WAIT;
          if (redirect_valid) begin
            pc_d   = redir_tgt_s;
            kill_d = 1'b1;
          end else begin
            kill_d = 1'b0;
          end
        end else if (redirect_valid) begin
          pc_d = redir_tgt_s;
        end else begin
          pc_d = pc_q;
        end
      end
      ST_WAIT: begin
        if (imem_rsp_valid) begin
          if (!kill_q && !redirect_valid) begin
            inst_d  = imem_rsp_data;
            state_d = ST_HOLD;
          end else begin
            kill_d  = 1'b0;
            state_d = ST_REQ;
            if (redirect_valid) begin
              pc_d = redir_tgt_s;
            end else begin
              pc_d = pc_q;
            end
          end
        end else if (redirect_valid) begin
          pc_d   = redir_tgt_s;
          kill_d = 1'b1;
        end else begin
          pc_d = pc_q;
        end
      end
      ST_HOLD: begin
        if (redirect_valid) begin
          pc_d    = redir_tgt_s;
          state_d = ST_REQ;
        end else if (out_fire_s) begin
          pc_d    = pc_q + 32'd4;
          state_d = ST_REQ;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_REQ;
        kill_d  = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_REQ;
      pc_q    <= RESET_PC;
      inst_q  <= 32'd0;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      kill_q  <= kill_d;
    end
  end

endmodule
